// File: rtl/foc_xform_seq_pkg.sv
// Shared op codes, sequencer state encoding and watchdog limit for the FOC transform sequencer.
package foc_pkg;

   localparam logic [1:0] OP_CLARKE  = 2'd0;
   localparam logic [1:0] OP_ICLARKE = 2'd1;
   localparam logic [1:0] OP_PARK    = 2'd2;
   localparam logic [1:0] OP_IPARK   = 2'd3;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_S1_GO   = 3'd1,
      SEQ_S1_WAIT = 3'd2,
      SEQ_S2_GO   = 3'd3,
      SEQ_S2_WAIT = 3'd4,
      SEQ_RESP    = 3'd5
   } seq_state_t;

   localparam int unsigned WDOG_LIMIT = 1023;

endpackage

// File: rtl/foc_xform_seq_if.sv
// Host (valid/ready) and matmul (start/done) signal bundle for foc_xform_seq.
interface foc_xform_seq_if #(
   parameter int D_WIDTH = 19
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_inv;
   logic signed [D_WIDTH-1:0] in_a;
   logic signed [D_WIDTH-1:0] in_b;
   logic signed [D_WIDTH-1:0] in_sin;
   logic signed [D_WIDTH-1:0] in_cos;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [D_WIDTH-1:0] out_a;
   logic signed [D_WIDTH-1:0] out_b;
   logic                      mm_start;
   logic [1:0]                mm_op;
   logic signed [D_WIDTH-1:0] mm_a;
   logic signed [D_WIDTH-1:0] mm_b;
   logic signed [D_WIDTH-1:0] mm_sin;
   logic signed [D_WIDTH-1:0] mm_cos;
   logic signed [D_WIDTH-1:0] mm_a_res;
   logic signed [D_WIDTH-1:0] mm_b_res;
   logic                      mm_done;
   logic                      err;

   // master: the sequencer; slave: host controller plus matmul engine
   modport master (
      input  in_valid, in_inv, in_a, in_b, in_sin, in_cos, out_ready,
             mm_a_res, mm_b_res, mm_done,
      output in_ready, out_valid, out_a, out_b,
             mm_start, mm_op, mm_a, mm_b, mm_sin, mm_cos, err
   );

   modport slave (
      output in_valid, in_inv, in_a, in_b, in_sin, in_cos, out_ready,
             mm_a_res, mm_b_res, mm_done,
      input  in_ready, out_valid, out_a, out_b,
             mm_start, mm_op, mm_a, mm_b, mm_sin, mm_cos, err
   );

endinterface

// File: rtl/foc_xform_seq.sv
// Two-stage FOC transform sequencer driving one matmul engine (Clarke->Park or invPark->invClarke).
// Optional WAIT-state watchdog enabled by defining FOC_SEQ_TIMEOUT_EN.
module foc_xform_seq
   import foc_pkg::*;
#(
   parameter int D_WIDTH = 19,
   parameter int Q_BITS  = 15
) (
   input logic             clk,
   input logic             rst,
   foc_xform_seq_if.master bus
);

   localparam logic [2:0] IDLE    = SEQ_IDLE;
   localparam logic [2:0] S1_GO   = SEQ_S1_GO;
   localparam logic [2:0] S1_WAIT = SEQ_S1_WAIT;
   localparam logic [2:0] S2_GO   = SEQ_S2_GO;
   localparam logic [2:0] S2_WAIT = SEQ_S2_WAIT;
   localparam logic [2:0] RESP    = SEQ_RESP;

   // Q_BITS only describes the data format; reject nonsensical combinations at elaboration
   if (Q_BITS < 0 || Q_BITS >= D_WIDTH) begin : g_qbits_invalid
      $error("foc_xform_seq: Q_BITS must lie in [0, D_WIDTH-1]");
   end

   logic [2:0]                state;
   logic                      inv_p0;
   logic [1:0]                op_p0;
   logic signed [D_WIDTH-1:0] a_p0;
   logic signed [D_WIDTH-1:0] b_p0;
   logic signed [D_WIDTH-1:0] sin_p0;
   logic signed [D_WIDTH-1:0] cos_p0;
   logic signed [D_WIDTH-1:0] res_a_p1;
   logic signed [D_WIDTH-1:0] res_b_p1;
   logic                      vld_p1;
   logic                      err_q;
   logic                      done_unexpected;

`ifdef FOC_SEQ_TIMEOUT_EN
   logic [9:0]                wdog;
   localparam logic [9:0]     WDOG_LAST = 10'(WDOG_LIMIT - 1);
`endif

   assign done_unexpected = bus.mm_done &&
                            (state == S1_GO || state == S2_GO || state == RESP);
   assign vld_p1          = (state == RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         inv_p0   <= 1'b0;
         op_p0    <= OP_CLARKE;
         a_p0     <= '0;
         b_p0     <= '0;
         sin_p0   <= '0;
         cos_p0   <= '0;
         res_a_p1 <= '0;
         res_b_p1 <= '0;
         err_q    <= 1'b0;
`ifdef FOC_SEQ_TIMEOUT_EN
         wdog     <= '0;
`endif
      end else begin
         if (done_unexpected)
            err_q <= 1'b1;

         case (state)
            // p0: request latched straight into the stage-1 operand registers
            IDLE: begin
               if (bus.in_valid) begin
                  inv_p0 <= bus.in_inv;
                  op_p0  <= bus.in_inv ? OP_IPARK : OP_CLARKE;
                  a_p0   <= bus.in_a;
                  b_p0   <= bus.in_b;
                  sin_p0 <= bus.in_sin;
                  cos_p0 <= bus.in_cos;
                  state  <= S1_GO;
               end
            end
            S1_GO: begin
               state <= S1_WAIT;
`ifdef FOC_SEQ_TIMEOUT_EN
               wdog  <= '0;
`endif
            end
            // stage-1 results become stage-2 operands; sin/cos stay as latched
            S1_WAIT: begin
               if (bus.mm_done) begin
                  a_p0  <= bus.mm_a_res;
                  b_p0  <= bus.mm_b_res;
                  op_p0 <= inv_p0 ? OP_ICLARKE : OP_PARK;
                  state <= S2_GO;
               end
`ifdef FOC_SEQ_TIMEOUT_EN
               else if (wdog == WDOG_LAST) begin
                  err_q    <= 1'b1;
                  res_a_p1 <= '0;
                  res_b_p1 <= '0;
                  state    <= RESP;
               end else begin
                  wdog <= wdog + 10'd1;
               end
`endif
            end
            S2_GO: begin
               state <= S2_WAIT;
`ifdef FOC_SEQ_TIMEOUT_EN
               wdog  <= '0;
`endif
            end
            // p1: final results held until the host takes them
            S2_WAIT: begin
               if (bus.mm_done) begin
                  res_a_p1 <= bus.mm_a_res;
                  res_b_p1 <= bus.mm_b_res;
                  state    <= RESP;
               end
`ifdef FOC_SEQ_TIMEOUT_EN
               else if (wdog == WDOG_LAST) begin
                  err_q    <= 1'b1;
                  res_a_p1 <= '0;
                  res_b_p1 <= '0;
                  state    <= RESP;
               end else begin
                  wdog <= wdog + 10'd1;
               end
`endif
            end
            RESP: begin
               if (bus.out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.mm_start  = (state == S1_GO) || (state == S2_GO);
   assign bus.mm_op     = op_p0;
   assign bus.mm_a      = a_p0;
   assign bus.mm_b      = b_p0;
   assign bus.mm_sin    = sin_p0;
   assign bus.mm_cos    = cos_p0;
   assign bus.out_valid = vld_p1;
   assign bus.out_a     = res_a_p1;
   assign bus.out_b     = res_b_p1;
   assign bus.err       = err_q;

endmodule
